// File: rtl/noc_avl_wr_arb_if.sv
// noc_avl_wr_arb_if: NoC channels in, Avalon write master, descriptor out; master=arbiter, slave=environment
interface noc_avl_wr_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int AVL_ADDR_WIDTH = 29,
  parameter int AVL_DATA_WIDTH = 512,
  parameter int FRAME_ID_WIDTH = 32,
  parameter int BIN_ADDR_WIDTH = 8,
  parameter int FRAME_OFFSET_WIDTH = 5,
  parameter int NOC_ADDR_WIDTH = 4
);
  localparam int WIDTH_PKT = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH;
  localparam int DESC_WIDTH = FRAME_ID_WIDTH + BIN_ADDR_WIDTH + FRAME_OFFSET_WIDTH + 1;
  logic [NUM_PORTS*WIDTH_PKT-1:0] noc_data_in;
  logic [NUM_PORTS-1:0] noc_valid_in;
  logic [NUM_PORTS-1:0] noc_ready_out;
  logic [AVL_ADDR_WIDTH-1:0] avl_addr;
  logic [AVL_DATA_WIDTH-1:0] avl_wdata;
  logic [AVL_DATA_WIDTH/8-1:0] avl_be;
  logic avl_write_req;
  logic avl_burstbegin;
  logic [2:0] avl_size;
  logic avl_ready;
  logic [DESC_WIDTH-1:0] noc_data_out;
  logic [NOC_ADDR_WIDTH-1:0] noc_dest_out;
  logic noc_valid_out;
  logic noc_ready_in;
  logic [15:0] drop_count;
  modport master (
    input noc_data_in, noc_valid_in, avl_ready, noc_ready_in,
    output noc_ready_out, avl_addr, avl_wdata, avl_be, avl_write_req, avl_burstbegin, avl_size,
    output noc_data_out, noc_dest_out, noc_valid_out, drop_count
  );
  modport slave (
    output noc_data_in, noc_valid_in, avl_ready, noc_ready_in,
    input noc_ready_out, avl_addr, avl_wdata, avl_be, avl_write_req, avl_burstbegin, avl_size,
    input noc_data_out, noc_dest_out, noc_valid_out, drop_count
  );
endinterface

// File: rtl/noc_avl_wr_arb.sv
// noc_avl_wr_arb: round-robin NoC frame to Avalon burst writer; ports clk, rst (async active-low), bus (noc_avl_wr_arb_if.master)
module noc_avl_wr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int AVL_ADDR_WIDTH = 29,
  parameter int AVL_DATA_WIDTH = 512,
  parameter int FRAME_ID_WIDTH = 32,
  parameter int BIN_ADDR_WIDTH = 8,
  parameter int FRAME_OFFSET_WIDTH = 5,
  parameter int NOC_ADDR_WIDTH = 4,
  parameter logic [NOC_ADDR_WIDTH-1:0] DEST_ADDR = '0
) (
  input logic clk,
  input logic rst,
  noc_avl_wr_arb_if.master bus
);
  localparam int WIDTH_PKT = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH;
  localparam int PW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, XFER, DESC} state_t;
  state_t r_state;
  logic [PW-1:0] r_grant, r_rr_ptr;
  logic [BIN_ADDR_WIDTH-1:0] r_next_bin;
  logic [FRAME_OFFSET_WIDTH-1:0] r_offset, r_len;
  logic r_trunc;
  logic [FRAME_ID_WIDTH-1:0] r_frame_id;
  logic [15:0] r_drop_count;
  logic [AVL_DATA_WIDTH-1:0] w_payload [NUM_PORTS];
  logic [FRAME_ID_WIDTH-1:0] w_fid [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_sof, w_eof, w_orphan;
  logic w_found, w_xfer, w_gvalid, w_accept, w_write;
  logic [PW-1:0] w_pick, w_idx;
  logic [4:0] w_drops;
  logic [16:0] w_drop_sum;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign w_payload[g] = bus.noc_data_in[g*WIDTH_PKT +: AVL_DATA_WIDTH];
    assign w_sof[g] = bus.noc_data_in[g*WIDTH_PKT + AVL_DATA_WIDTH];
    assign w_eof[g] = bus.noc_data_in[g*WIDTH_PKT + AVL_DATA_WIDTH + 1];
    assign w_fid[g] = bus.noc_data_in[g*WIDTH_PKT + AVL_DATA_WIDTH + 2 +: FRAME_ID_WIDTH];
  end
  assign w_orphan = (rst && r_state == IDLE) ? bus.noc_valid_in & ~w_sof : '0;
  always_comb begin
    w_found = 1'b0;
    w_pick = '0;
    w_idx = '0;
    w_drops = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % NUM_PORTS);
      if (bus.noc_valid_in[w_idx] && w_sof[w_idx]) begin
        w_found = 1'b1;
        w_pick = w_idx;
      end
      w_drops = w_drops + 5'(w_orphan[k]);
    end
  end
  assign w_drop_sum = {1'b0, r_drop_count} + {12'd0, w_drops};
  assign w_xfer = r_state == XFER;
  assign w_gvalid = bus.noc_valid_in[r_grant];
  assign w_accept = w_xfer && w_gvalid && (r_trunc || bus.avl_ready);
  assign w_write = w_xfer && w_gvalid && !r_trunc;
  always_comb begin
    bus.noc_ready_out = w_orphan;
    if (w_xfer) bus.noc_ready_out[r_grant] = r_trunc || bus.avl_ready;
  end
  assign bus.avl_write_req = w_write;
  assign bus.avl_burstbegin = w_write && r_offset == '0;
  assign bus.avl_wdata = w_xfer ? w_payload[r_grant] : '0;
  assign bus.avl_be = {(AVL_DATA_WIDTH/8){w_xfer}};
  assign bus.avl_size = w_xfer ? 3'd1 : 3'd0;
  assign bus.avl_addr = AVL_ADDR_WIDTH'({r_next_bin, r_offset});
  assign bus.noc_valid_out = r_state == DESC;
  assign bus.noc_dest_out = DEST_ADDR;
  assign bus.noc_data_out = {r_trunc, r_len, r_next_bin, r_frame_id};
  assign bus.drop_count = r_drop_count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rr_ptr <= '0;
      r_next_bin <= '0;
      r_offset <= '0;
      r_len <= '0;
      r_trunc <= 1'b0;
      r_frame_id <= '0;
      r_drop_count <= '0;
    end else begin
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      case (r_state)
        IDLE: if (w_found) begin
          r_grant <= w_pick;
          r_frame_id <= w_fid[w_pick];
          r_offset <= '0;
          r_trunc <= 1'b0;
          r_state <= XFER;
        end
        XFER: if (w_accept) begin
          if (!r_trunc) r_offset <= r_offset + 1'b1;
          if (w_eof[r_grant]) begin
            r_len <= r_trunc ? '0 : r_offset + 1'b1;
            r_state <= DESC;
          end else if (!r_trunc && &r_offset) r_trunc <= 1'b1;
        end
        DESC: if (bus.noc_ready_in) begin
          r_next_bin <= r_next_bin + 1'b1;
          r_rr_ptr <= PW'((int'(r_grant) + 1) % NUM_PORTS);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
